mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS core.
- Sequences a shared byte-addressed, big-endian unified instruction/data memory, the IR, the register file, the ALU and the PC, one instruction at a time.
- Decodes the opcode/funct held in IR and drives Moore-style control per state.
- Counts retired instructions and halts on an illegal opcode.

---
 rtl/mips_multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with retired-instruction counter and illegal-opcode halt
module mips_multicycle_ctrl #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB,
        BRANCH, ADDI_EX, ADDI_WB, JUMP, JR, HALT
    } state_t;
    state_t cur, nxt, ill;
    logic pc_en_c, ir_write_c, mem_write_c, reg_write_c, fn_ok, illegal;
    logic [2:0] fn_alu;
    assign ill = HALT_ON_ILLEGAL ? HALT : FETCH;
    assign fn_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    assign fn_alu = funct == 6'b100010 ? 3'b110 :
                    funct == 6'b100100 ? 3'b000 :
                    funct == 6'b100101 ? 3'b001 :
                    funct == 6'b101010 ? 3'b111 : 3'b010;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= FETCH;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (nxt == FETCH && cur != FETCH && cur <= JR && !illegal)
                instr_count <= instr_count + 1'b1;
        end
    end
    always_comb begin
        nxt         = FETCH;
        illegal     = 1'b0;
        pc_en_c     = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        i_or_d      = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = 3'b010;
        pc_src      = 2'b00;
        case (cur)
            FETCH: begin
                ir_write_c = 1'b1;
                pc_en_c    = 1'b1;
                alu_src_b  = 2'b01;
                nxt        = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000: begin
                        nxt     = funct == 6'b001000 ? JR : fn_ok ? RTYPE_EX : ill;
                        illegal = funct != 6'b001000 && !fn_ok;
                    end
                    6'b000100, 6'b000101: nxt = BRANCH;
                    6'b001000:            nxt = ADDI_EX;
                    6'b000010, 6'b000011: nxt = JUMP;
                    default: begin
                        nxt     = ill;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = opcode == 6'b100011 ? MEMRD : MEMWR;
            end
            MEMRD: begin
                i_or_d = 1'b1;
                nxt    = MEMWB;
            end
            MEMWB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 2'b01;
            end
            MEMWR: begin
                i_or_d      = 1'b1;
                mem_write_c = 1'b1;
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_ctrl  = fn_alu;
                nxt       = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write_c = 1'b1;
                reg_dst     = 2'b01;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 3'b110;
                pc_src    = 2'b01;
                pc_en_c   = opcode[0] ? !zero : zero;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDI_WB;
            end
            ADDI_WB: reg_write_c = 1'b1;
            JUMP: begin
                pc_en_c     = 1'b1;
                pc_src      = 2'b10;
                reg_write_c = opcode[0];
                reg_dst     = opcode[0] ? 2'b10 : 2'b00;
                mem_to_reg  = opcode[0] ? 2'b10 : 2'b00;
            end
            JR: begin
                pc_en_c = 1'b1;
                pc_src  = 2'b11;
            end
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end
    assign pc_en     = pc_en_c & ~rst;
    assign ir_write  = ir_write_c & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign state     = cur;
    assign halted    = cur == HALT;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: per-instruction path model checked against both halting and non-halting controllers
module tb_mips_multicycle_ctrl;
    logic clk = 0, rst = 1, rst0 = 1, zero = 0;
    logic [5:0] opcode = 0, funct = 0;
    always #5 clk = ~clk;

    logic pc_en1, i_or_d1, mem_write1, ir_write1, reg_write1, alu_src_a1, halted1;
    logic [1:0] reg_dst1, mem_to_reg1, alu_src_b1, pc_src1;
    logic [2:0] alu_ctrl1;
    logic [3:0] state1;
    logic [31:0] cnt1;
    logic pc_en0, i_or_d0, mem_write0, ir_write0, reg_write0, alu_src_a0, halted0;
    logic [1:0] reg_dst0, mem_to_reg0, alu_src_b0, pc_src0;
    logic [2:0] alu_ctrl0;
    logic [3:0] state0;
    logic [31:0] cnt0;

    mips_multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en1), .i_or_d(i_or_d1), .mem_write(mem_write1), .ir_write(ir_write1),
        .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_ctrl(alu_ctrl1),
        .pc_src(pc_src1), .state(state1), .halted(halted1), .instr_count(cnt1));

    mips_multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en0), .i_or_d(i_or_d0), .mem_write(mem_write0), .ir_write(ir_write0),
        .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_ctrl(alu_ctrl0),
        .pc_src(pc_src0), .state(state0), .halted(halted0), .instr_count(cnt0));

    typedef struct packed {
        logic pc_en, i_or_d, mem_write, ir_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic [3:0] state;
        logic halted;
        logic [31:0] cnt;
    } ctl_t;

    ctl_t exp_c, act;
    logic chk_en = 0, sel = 1;
    int tests = 0, fails = 0, cnt = 0;

    assign act = sel ?
        {pc_en1, i_or_d1, mem_write1, ir_write1, reg_write1, reg_dst1, mem_to_reg1,
         alu_src_a1, alu_src_b1, alu_ctrl1, pc_src1, state1, halted1, cnt1} :
        {pc_en0, i_or_d0, mem_write0, ir_write0, reg_write0, reg_dst0, mem_to_reg0,
         alu_src_a0, alu_src_b0, alu_ctrl0, pc_src0, state0, halted0, cnt0};

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (act !== exp_c) begin
                fails++;
                $display("FAIL ctl dut%0d st=%0d: got %h (state %0d) expected %h", sel, exp_c.state, act, act.state, exp_c);
            end
        end
    end

    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic ctl_t spec_out(input int st, input logic [5:0] op, fn, input logic z, input int c_in);
        ctl_t c;
        int a;
        c = '0;
        c.alu_ctrl = 3'b010;
        c.state = 4'(st);
        c.cnt = c_in;
        a = alu_of(fn);
        case (st)
            0:  begin c.ir_write = 1; c.pc_en = 1; c.alu_src_b = 2'b01; end
            1:  c.alu_src_b = 2'b11;
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  c.i_or_d = 1;
            4:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            5:  begin c.i_or_d = 1; c.mem_write = 1; end
            6:  begin c.alu_src_a = 1; c.alu_ctrl = 3'(a); end
            7:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
            8:  begin
                    c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01;
                    c.pc_en = (op == 6'b000100 && z) || (op == 6'b000101 && !z);
                end
            9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            10: c.reg_write = 1;
            11: begin
                    c.pc_en = 1; c.pc_src = 2'b10;
                    if (op == 6'b000011) begin c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
                end
            12: begin c.pc_en = 1; c.pc_src = 2'b11; end
            13: c.halted = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic step(input ctl_t e);
        exp_c = e;
        chk_en = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        ctl_t e;
        rst = 1;
        rst0 = 1;
        chk_en = 0;
        @(posedge clk);
        #1;
        cnt = 0;
        e = spec_out(0, opcode, funct, 0, 0);
        e.pc_en = 0;
        e.ir_write = 0;
        repeat (n - 1) step(e);
        if (sel) rst = 0; else rst0 = 0;
    endtask

    // Each instruction is modelled as its list of visited states; two entries means it was illegal.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int p[$];
        opcode = op;
        funct = fn;
        zero = z;
        p.push_back(0);
        p.push_back(1);
        case (op)
            6'b100011: begin p.push_back(2); p.push_back(3); p.push_back(4); end
            6'b101011: begin p.push_back(2); p.push_back(5); end
            6'b000000:
                if (fn == 6'b001000) p.push_back(12);
                else if (alu_of(fn) >= 0) begin p.push_back(6); p.push_back(7); end
            6'b000100, 6'b000101: p.push_back(8);
            6'b001000: begin p.push_back(9); p.push_back(10); end
            6'b000010, 6'b000011: p.push_back(11);
            default: ;
        endcase
        foreach (p[i]) step(spec_out(p[i], op, fn, z, cnt));
        if (p.size() > 2) cnt++;
        else if (sel) repeat (20) step(spec_out(13, op, fn, z, cnt));
    endtask

    logic [5:0] fns [5] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};

    initial begin
        opcode = 6'b100011;
        do_reset(3);
        #1;
        lit("post-reset ir_write", 32'(ir_write1), 1);
        lit("post-reset pc_en", 32'(pc_en1), 1);
        run(6'b100011, 6'b0, 0);
        run(6'b101011, 6'b0, 0);
        lit("count after lw,sw", cnt1, 2);
        run(6'b000101, 6'b0, 0);
        run(6'b000101, 6'b0, 1);
        run(6'b000100, 6'b0, 1);
        run(6'b000100, 6'b0, 0);
        run(6'b000011, 6'b0, 0);
        run(6'b000000, 6'b001000, 0);
        for (int i = 0; i < 5; i++) run(6'b000000, fns[i], 0);
        run(6'b001000, 6'b0, 0);
        run(6'b000010, 6'b0, 1);
        lit("count before illegal", cnt1, 15);
        run(6'b111111, 6'b0, 0);
        lit("halt state", 32'(state1), 13);
        lit("halt count", cnt1, 15);
        do_reset(2);
        lit("state after halt reset", 32'(state1), 0);
        run(6'b001000, 6'b0, 0);
        sel = 0;
        do_reset(2);
        run(6'b100011, 6'b0, 0);
        run(6'b111111, 6'b0, 0);
        lit("nop state", 32'(state0), 0);
        lit("nop count", cnt0, 1);
        run(6'b000000, 6'b000001, 0);
        run(6'b001000, 6'b0, 0);
        lit("count after nops", cnt0, 2);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
